fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 36 +++
 rtl/fifo_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO pointer controller and its status-flag bundle.
package fifo_pkg;

   localparam int FIFO_ADDR_W    = 5;
   localparam int FIFO_DEPTH     = 1 << FIFO_ADDR_W;
   localparam int FIFO_AFULL_TH  = 28;
   localparam int FIFO_AEMPTY_TH = 4;

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } fifo_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Enable-gated pointer counter carrying an extra wrap bit above the RAM address.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   output logic [ADDR_W:0] ptr
);

   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W:0] ptr_d;
   logic [ADDR_W:0] ptr_q;

   // Natural overflow of the ADDR_W+1 bit adder gives the modulo wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = ptr_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a dual-port RAM FIFO; holds no data storage itself.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = FIFO_ADDR_W,
   parameter int AFULL_TH  = FIFO_AFULL_TH,
   parameter int AEMPTY_TH = FIFO_AEMPTY_TH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   output logic            w_en,
   output logic [ADDR_W:0] w_addr,
   output logic            r_en,
   output logic [ADDR_W:0] r_addr,
   output logic            rd_valid,
   output logic            full,
   output logic            empty,
   output logic            afull,
   output logic            aempty,
   output logic [ADDR_W:0] count,
   output logic            overflow,
   output logic            underflow
);

   localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W + 1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_V = (ADDR_W + 1)'(AEMPTY_TH);

   logic            push_acc;
   logic            pop_acc;
   logic [ADDR_W:0] w_ptr;
   logic [ADDR_W:0] r_ptr;
   logic [ADDR_W:0] count_w;
   fifo_flags_t     flags;

   logic rd_valid_d;
   logic rd_valid_q;
   logic overflow_d;
   logic overflow_q;
   logic underflow_d;
   logic underflow_q;

   fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .en  (push_acc),
      .ptr (w_ptr)
   );

   fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .en  (pop_acc),
      .ptr (r_ptr)
   );

   // A push into a full FIFO is still legal when a pop frees the slot in the same cycle.
   always_comb begin
      count_w      = w_ptr - r_ptr;
      flags.empty  = (w_ptr == r_ptr);
      flags.full   = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                     (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
      flags.afull  = (count_w >= AFULL_V);
      flags.aempty = (count_w <= AEMPTY_V);
      pop_acc      = pop && !flags.empty && !rst;
      push_acc     = push && (!flags.full || pop_acc) && !rst;
   end

   always_comb begin
      rd_valid_d  = pop_acc;
      overflow_d  = overflow_q || (push && !push_acc);
      underflow_d = underflow_q || (pop && !pop_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign w_en      = push_acc;
   assign r_en      = pop_acc;
   assign w_addr    = w_ptr;
   assign r_addr    = r_ptr;
   assign count     = count_w;
   assign full      = flags.full;
   assign empty     = flags.empty;
   assign afull     = flags.afull;
   assign aempty    = flags.aempty;
   assign rd_valid  = rd_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized self-checking bench for fifo_ctrl against a queue-based FIFO model.
module tb_fifo_ctrl;
   import fifo_pkg::*;

   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          push;
   logic          pop;
   logic          w_en;
   logic [AW:0]   w_addr;
   logic          r_en;
   logic [AW:0]   r_addr;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          afull;
   logic          aempty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   logic [7:0]    d_in;
   logic [7:0]    d_out;
   logic [7:0]    mem [0:DEPTH-1];

   byte unsigned  q[$];
   int            m_wptr;
   int            m_rptr;
   bit            m_ovf;
   bit            m_unf;
   bit            m_rdv;
   logic [7:0]    m_dout;

   int            checks   = 0;
   int            failures = 0;
   int            prevW    = 0;
   bit            wrapSeen = 0;
   int            maxCnt   = 0;

   always #5 clk = ~clk;

   fifo_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .w_en      (w_en),
      .w_addr    (w_addr),
      .r_en      (r_en),
      .r_addr    (r_addr),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .afull     (afull),
      .aempty    (aempty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // Stand-in for the 32x8 dual-port RAM with registered read data.
   always @(posedge clk) begin
      if (w_en) mem[w_addr[AW-1:0]] <= d_in;
      if (r_en) d_out <= mem[r_addr[AW-1:0]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState();
      int cnt;
      cnt = q.size();
      checkOutput("count", 32'(count), cnt);
      checkOutput("empty", 32'(empty), (cnt == 0));
      checkOutput("full", 32'(full), (cnt == DEPTH));
      checkOutput("afull", 32'(afull), (cnt >= 28));
      checkOutput("aempty", 32'(aempty), (cnt <= 4));
      checkOutput("overflow", 32'(overflow), m_ovf);
      checkOutput("underflow", 32'(underflow), m_unf);
      checkOutput("rd_valid", 32'(rd_valid), m_rdv);
      checkOutput("w_addr", 32'(w_addr), m_wptr);
      checkOutput("r_addr", 32'(r_addr), m_rptr);
      if (m_rdv) checkOutput("d_out", 32'(d_out), 32'(m_dout));
      if (prevW == 63 && w_addr == 0) wrapSeen = 1;
      prevW = int'(w_addr);
      if (int'(count) > maxCnt) maxCnt = int'(count);
   endtask

   // One clock cycle: drive at the falling edge, check enables, then check state after the edge.
   task automatic applyStimulus(input bit doRst, input bit doPush, input bit doPop,
                                input logic [7:0] data);
      bit popAcc;
      bit pushAcc;
      int cnt;
      @(negedge clk);
      rst  = doRst;
      push = doPush;
      pop  = doPop;
      d_in = data;
      #1;
      cnt     = q.size();
      popAcc  = !doRst && doPop && (cnt > 0);
      pushAcc = !doRst && doPush && ((cnt < DEPTH) || popAcc);
      checkOutput("w_en", 32'(w_en), pushAcc);
      checkOutput("r_en", 32'(r_en), popAcc);
      @(posedge clk);
      if (doRst) begin
         q.delete();
         m_wptr = 0;
         m_rptr = 0;
         m_ovf  = 0;
         m_unf  = 0;
         m_rdv  = 0;
      end else begin
         if (popAcc) begin
            m_dout = q.pop_front();
            m_rptr = (m_rptr + 1) % 64;
         end
         if (pushAcc) begin
            q.push_back(data);
            m_wptr = (m_wptr + 1) % 64;
         end
         m_ovf = m_ovf || (doPush && !pushAcc);
         m_unf = m_unf || (doPop && !popAcc);
         m_rdv = popAcc;
      end
      #1;
      checkState();
   endtask

   initial begin
      int pPush;
      int pPop;
      rst  = 1'b1;
      push = 1'b0;
      pop  = 1'b0;
      d_in = 8'h00;
      m_wptr = 0;
      m_rptr = 0;
      m_ovf  = 0;
      m_unf  = 0;
      m_rdv  = 0;
      m_dout = 8'h00;

      applyStimulus(1, 0, 0, 8'h00);
      applyStimulus(1, 1, 1, 8'h55);

      for (int i = 0; i < 32; i++) applyStimulus(0, 1, 0, 8'(i));
      applyStimulus(0, 1, 0, 8'hEE);
      for (int i = 0; i < 32; i++) applyStimulus(0, 0, 1, 8'h00);
      applyStimulus(0, 0, 1, 8'h00);

      for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, 8'(8'h40 + i));
      applyStimulus(1, 1, 1, 8'h77);

      applyStimulus(0, 1, 1, 8'hA0);
      for (int i = 1; i < 32; i++) applyStimulus(0, 1, 0, 8'(8'hA0 + i));
      applyStimulus(0, 1, 1, 8'hCC);
      applyStimulus(0, 0, 1, 8'h00);

      applyStimulus(1, 0, 0, 8'h00);
      maxCnt   = 0;
      wrapSeen = 0;
      for (int i = 0; i < 70; i++) begin
         applyStimulus(0, 1, 0, 8'(i * 3));
         applyStimulus(0, 0, 1, 8'h00);
      end
      checkOutput("wrap_seen", 32'(wrapSeen), 1);
      checkOutput("wrap_max_count", 32'(maxCnt <= 1), 1);

      for (int phase = 0; phase < 6; phase++) begin
         pPush = (phase % 3 == 0) ? 80 : ((phase % 3 == 1) ? 20 : 50);
         pPop  = 100 - pPush;
         for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 99) < pPush),
                          ($urandom_range(0, 99) < pPop),
                          8'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
